// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: operation encoding, flag bit positions, FSM states.
// SEQ_ALU_MUL_EN adds the multiply state.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_SELA = 4'd0,
    OP_SELB = 4'd1,
    OP_ADD  = 4'd2,
    OP_ADC  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SBB  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SAR  = 4'd11,
    OP_ROL  = 4'd12,
    OP_ROR  = 4'd13,
    OP_MUL  = 4'd14
  } alu_op_t;

  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int AF_IDX = 4;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int OF_IDX = 11;

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

  function automatic logic is_rotate_op(input alu_op_t op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// One-bit shift/rotate step with the carry-out and the single-step overflow bit.
// Byte mode confines the step to bits [7:0] and zeroes the upper bits.
module seq_alu_shifter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_t            op_i,
  input  logic               is_8_bit_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               cf_o,
  output logic               of_o
);

  logic [7:0]       b_in;
  logic [7:0]       b_res;
  logic [WIDTH-1:0] w_res;
  logic             b_cf;
  logic             w_cf;
  logic             msb_in;
  logic             r_msb;
  logic             r_msb1;

  always_comb begin
    b_in  = data_i[7:0];
    b_res = b_in;
    w_res = data_i;
    b_cf  = 1'b0;
    w_cf  = 1'b0;
    case (op_i)
      OP_SHL: begin
        b_res = {b_in[6:0], 1'b0};
        b_cf  = b_in[7];
        w_res = {data_i[WIDTH-2:0], 1'b0};
        w_cf  = data_i[WIDTH-1];
      end
      OP_SHR: begin
        b_res = {1'b0, b_in[7:1]};
        b_cf  = b_in[0];
        w_res = {1'b0, data_i[WIDTH-1:1]};
        w_cf  = data_i[0];
      end
      OP_SAR: begin
        b_res = {b_in[7], b_in[7:1]};
        b_cf  = b_in[0];
        w_res = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        w_cf  = data_i[0];
      end
      OP_ROL: begin
        b_res = {b_in[6:0], b_in[7]};
        b_cf  = b_in[7];
        w_res = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        w_cf  = data_i[WIDTH-1];
      end
      OP_ROR: begin
        b_res = {b_in[0], b_in[7:1]};
        b_cf  = b_in[0];
        w_res = {data_i[0], data_i[WIDTH-1:1]};
        w_cf  = data_i[0];
      end
      default: ;
    endcase

    data_o = is_8_bit_i ? {{(WIDTH-8){1'b0}}, b_res} : w_res;
    cf_o   = is_8_bit_i ? b_cf : w_cf;
    msb_in = is_8_bit_i ? b_in[7] : data_i[WIDTH-1];
    r_msb  = is_8_bit_i ? b_res[7] : w_res[WIDTH-1];
    r_msb1 = is_8_bit_i ? b_res[6] : w_res[WIDTH-2];

    // OF is only architecturally meaningful for a single-bit step.
    of_o = 1'b0;
    case (op_i)
      OP_SHL, OP_ROL: of_o = r_msb ^ cf_o;
      OP_SHR:         of_o = msb_in;
      OP_ROR:         of_o = r_msb ^ r_msb1;
      default:        of_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential x86-style ALU: single-cycle arithmetic/logic, bit-serial shifts and
// (with SEQ_ALU_MUL_EN defined) a bit-serial unsigned shift-add multiplier.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CNT_BITS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  alu_op_t           op,
  input  logic              is_8_bit,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [15:0]       flags_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  out_hi,
  output logic [15:0]       flags_out,
  output state_t            state_dbg
);

  localparam int MUL_CW = $clog2(WIDTH + 1);
  localparam int CW     = (CNT_BITS > MUL_CW) ? CNT_BITS : MUL_CW;

  // Handshake: start is taken on a rising edge where busy=0 (state IDLE);
  // busy covers the iteration cycles, done pulses once with results that
  // stay held until the next accepted start.
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  alu_op_t          op_q, op_d;
  logic             is8_q, is8_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      fin_q, fin_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;
  logic [15:0]      flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]  am, bm;
  logic              cin;
  logic [WIDTH:0]    sum_w, dif_w;
  logic [CNT_BITS-1:0] cnt_in;

  logic             in_shift;
  alu_op_t          sh_op;
  logic             sh_is8;
  logic [WIDTH-1:0] sh_din, sh_dout;
  logic             sh_cf, sh_of;

  logic [WIDTH-1:0] res1;
  logic [15:0]      f1;
  logic [15:0]      fs;
  logic             iter;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_src, p_step;
  logic [WIDTH-1:0]   m_src, mc_src;
  logic               in_mul;
  logic               hi_nz;
`endif

  function automatic logic [WIDTH-1:0] mask_w(input logic [WIDTH-1:0] v, input logic is8);
    return is8 ? {{(WIDTH-8){1'b0}}, v[7:0]} : v;
  endfunction

  function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic is8);
    return is8 ? v[7] : v[WIDTH-1];
  endfunction

  function automatic logic [15:0] set_pzs(input logic [15:0] f, input logic [WIDTH-1:0] r,
                                          input logic is8);
    logic [15:0] g;
    g         = f;
    g[PF_IDX] = ~^r[7:0];
    g[ZF_IDX] = is8 ? (r[7:0] == 8'h00) : (r == '0);
    g[SF_IDX] = is8 ? r[7] : r[WIDTH-1];
    return g;
  endfunction

  assign am     = mask_w(a, is_8_bit);
  assign bm     = mask_w(b, is_8_bit);
  assign cin    = flags_in[CF_IDX] & ((op == OP_ADC) || (op == OP_SBB));
  assign sum_w  = {1'b0, am} + {1'b0, bm} + {{WIDTH{1'b0}}, cin};
  assign dif_w  = {1'b0, am} - {1'b0, bm} - {{WIDTH{1'b0}}, cin};
  assign cnt_in = b[CNT_BITS-1:0];

  // The shifter serves the first step at accept time and every later step.
  assign in_shift = (state_q == ST_SHIFT);
  assign sh_op    = in_shift ? op_q : op;
  assign sh_is8   = in_shift ? is8_q : is_8_bit;
  assign sh_din   = in_shift ? data_q : a;

  seq_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op_i       (sh_op),
    .is_8_bit_i (sh_is8),
    .data_i     (sh_din),
    .data_o     (sh_dout),
    .cf_o       (sh_cf),
    .of_o       (sh_of)
  );

`ifdef SEQ_ALU_MUL_EN
  // MSB-first shift-add: prod = 2*prod + bit*mcand, first step taken at accept.
  assign in_mul = (state_q == ST_MUL);
  assign m_src  = in_mul ? mplier_q : (is_8_bit ? {a[7:0], {(WIDTH-8){1'b0}}} : a);
  assign p_src  = in_mul ? prod_q : '0;
  assign mc_src = in_mul ? mcand_q : bm;
  assign p_step = (p_src << 1) + (m_src[WIDTH-1] ? {{WIDTH{1'b0}}, mc_src} : '0);
  assign hi_nz  = is8_q ? (|p_step[15:8]) : (|p_step[2*WIDTH-1:WIDTH]);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    is8_d    = is8_q;
    data_d   = data_q;
    fin_d    = fin_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    res1     = am;
    f1       = flags_in;
    fs       = fin_q;
    iter     = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    prod_d   = prod_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          is8_d = is_8_bit;
          fin_d = flags_in;
          case (op)
            OP_SELA: res1 = am;
            OP_SELB: res1 = bm;
            OP_ADD, OP_ADC: begin
              res1      = mask_w(sum_w[WIDTH-1:0], is_8_bit);
              f1[CF_IDX] = is_8_bit ? sum_w[8] : sum_w[WIDTH];
              f1[OF_IDX] = (msb_of(am, is_8_bit) == msb_of(bm, is_8_bit)) &&
                           (msb_of(res1, is_8_bit) != msb_of(am, is_8_bit));
              f1[AF_IDX] = am[4] ^ bm[4] ^ res1[4];
              f1        = set_pzs(f1, res1, is_8_bit);
            end
            OP_SUB, OP_SBB: begin
              res1      = mask_w(dif_w[WIDTH-1:0], is_8_bit);
              f1[CF_IDX] = is_8_bit ? dif_w[8] : dif_w[WIDTH];
              f1[OF_IDX] = (msb_of(am, is_8_bit) != msb_of(bm, is_8_bit)) &&
                           (msb_of(res1, is_8_bit) != msb_of(am, is_8_bit));
              f1[AF_IDX] = am[4] ^ bm[4] ^ res1[4];
              f1        = set_pzs(f1, res1, is_8_bit);
            end
            OP_AND, OP_OR, OP_XOR: begin
              if (op == OP_AND)     res1 = am & bm;
              else if (op == OP_OR) res1 = am | bm;
              else                  res1 = am ^ bm;
              f1[CF_IDX] = 1'b0;
              f1[OF_IDX] = 1'b0;
              f1        = set_pzs(f1, res1, is_8_bit);
            end
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
              if (cnt_in == CNT_BITS'(1)) begin
                res1      = sh_dout;
                f1[CF_IDX] = sh_cf;
                f1[OF_IDX] = sh_of;
                if (!is_rotate_op(op)) f1 = set_pzs(f1, res1, is_8_bit);
              end else if (cnt_in != '0) begin
                iter    = 1'b1;
                state_d = ST_SHIFT;
                data_d  = sh_dout;
                cnt_d   = CW'(cnt_in) - CW'(1);
              end
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
              iter     = 1'b1;
              state_d  = ST_MUL;
              prod_d   = p_step;
              mplier_d = m_src << 1;
              mcand_d  = bm;
              cnt_d    = is_8_bit ? CW'(7) : CW'(WIDTH - 1);
            end
`endif
            default: ;
          endcase
          if (!iter) begin
            out_d    = res1;
            out_hi_d = '0;
            flags_d  = f1;
            done_d   = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        data_d = sh_dout;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          out_d      = sh_dout;
          out_hi_d   = '0;
          fs[CF_IDX] = sh_cf;
          if (!is_rotate_op(op_q)) fs = set_pzs(fs, sh_dout, is8_q);
          flags_d    = fs;
        end
      end

`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        prod_d   = p_step;
        mplier_d = mplier_q << 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          out_d      = p_step[WIDTH-1:0];
          out_hi_d   = is8_q ? '0 : p_step[2*WIDTH-1:WIDTH];
          fs[CF_IDX] = hi_nz;
          fs[OF_IDX] = hi_nz;
          fs         = set_pzs(fs, p_step[WIDTH-1:0], is8_q);
          flags_d    = fs;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_SELA;
      is8_q    <= 1'b0;
      data_q   <= '0;
      fin_q    <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      prod_q   <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      is8_q    <= is8_d;
      data_q   <= data_d;
      fin_q    <= fin_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
`ifdef SEQ_ALU_MUL_EN
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign flags_out = flags_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with hand-computed results,
// latencies and flags; MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  alu_op_t      op;
  logic         is_8_bit;
  logic [W-1:0] a, b;
  logic [15:0]  flags_in;
  logic         busy, done;
  logic [W-1:0] out, out_hi;
  logic [15:0]  flags_out;
  state_t       state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  seq_alu #(.WIDTH(W), .CNT_BITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .is_8_bit  (is_8_bit),
    .a         (a),
    .b         (b),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .out_hi    (out_hi),
    .flags_out (flags_out),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Drive one start across a rising edge, then scramble the operands so any
  // late sampling of the inputs shows up in the result.
  task automatic issue(input alu_op_t o, input logic is8, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [15:0] fl);
    start    = 1'b1;
    op       = o;
    is_8_bit = is8;
    a        = aa;
    b        = bb;
    flags_in = fl;
    @(negedge clk);
    start    = 1'b0;
    a        = W'($urandom_range(0, 65535));
    b        = W'($urandom_range(0, 65535));
    flags_in = 16'($urandom_range(0, 65535));
    is_8_bit = 1'($urandom_range(0, 1));
  endtask

  // Latency in cycles after the accepting edge; -1 on timeout.
  task automatic wait_done(input int from, output int l);
    l = -1;
    for (int i = from; i <= 40; i++) begin
      if (done === 1'b1) begin
        l = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = OP_SELA; is_8_bit = 1'b0;
    a = '0; b = '0; flags_in = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (out !== 16'h0) $display("FAIL reset_out: got %h want 0000", out); else n_pass++;
    n_checks++; if (out_hi !== 16'h0) $display("FAIL reset_out_hi: got %h want 0000", out_hi); else n_pass++;
    n_checks++; if (flags_out !== 16'h0) $display("FAIL reset_flags: got %h want 0000", flags_out); else n_pass++;
    n_checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_arith();
    issue(OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h0200);
    wait_done(1, lat);
    n_checks++; if (lat !== 1) $display("FAIL add_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (out !== 16'h8000) $display("FAIL add_out: got %h want 8000", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0A94) $display("FAIL add_flags: got %h want 0a94", flags_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL add_busy: got %b want 0", busy); else n_pass++;

    issue(OP_SUB, 1'b0, 16'h0000, 16'h0001, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (out !== 16'hFFFF) $display("FAIL sub_out: got %h want ffff", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0095) $display("FAIL sub_flags: got %h want 0095", flags_out); else n_pass++;

    issue(OP_ADC, 1'b1, 16'h12FF, 16'h0000, 16'h0001);
    wait_done(1, lat);
    n_checks++; if (out !== 16'h0000) $display("FAIL adc8_out: got %h want 0000", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0055) $display("FAIL adc8_flags: got %h want 0055", flags_out); else n_pass++;

    issue(OP_SBB, 1'b1, 16'h0080, 16'h0000, 16'h0001);
    wait_done(1, lat);
    n_checks++; if (out !== 16'h007F) $display("FAIL sbb8_out: got %h want 007f", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0810) $display("FAIL sbb8_flags: got %h want 0810", flags_out); else n_pass++;
  endtask

  task automatic test_logic();
    issue(OP_AND, 1'b0, 16'hF0F0, 16'h0FF0, 16'h0811);
    wait_done(1, lat);
    n_checks++; if (out !== 16'h00F0) $display("FAIL and_out: got %h want 00f0", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0014) $display("FAIL and_flags: got %h want 0014", flags_out); else n_pass++;

    issue(OP_XOR, 1'b1, 16'h0055, 16'h0055, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (out !== 16'h0000) $display("FAIL xor8_out: got %h want 0000", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0044) $display("FAIL xor8_flags: got %h want 0044", flags_out); else n_pass++;

    issue(OP_SELB, 1'b0, 16'h5555, 16'h1234, 16'h0ACD);
    wait_done(1, lat);
    n_checks++; if (out !== 16'h1234) $display("FAIL selb_out: got %h want 1234", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0ACD) $display("FAIL selb_flags: got %h want 0acd", flags_out); else n_pass++;
  endtask

  task automatic test_shift();
    issue(OP_SHL, 1'b1, 16'h0081, 16'h0003, 16'h0800);
    n_checks++; if (busy !== 1'b1) $display("FAIL shl8_busy: got %b want 1", busy); else n_pass++;
    wait_done(1, lat);
    n_checks++; if (lat !== 3) $display("FAIL shl8_lat: got %0d want 3", lat); else n_pass++;
    n_checks++; if (out !== 16'h0008) $display("FAIL shl8_out: got %h want 0008", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0800) $display("FAIL shl8_flags: got %h want 0800", flags_out); else n_pass++;

    issue(OP_SHR, 1'b0, 16'h0003, 16'h0021, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (lat !== 1) $display("FAIL shr1_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (out !== 16'h0001) $display("FAIL shr1_out: got %h want 0001", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0001) $display("FAIL shr1_flags: got %h want 0001", flags_out); else n_pass++;

    issue(OP_SAR, 1'b0, 16'h8001, 16'h0004, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (lat !== 4) $display("FAIL sar4_lat: got %0d want 4", lat); else n_pass++;
    n_checks++; if (out !== 16'hF800) $display("FAIL sar4_out: got %h want f800", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0084) $display("FAIL sar4_flags: got %h want 0084", flags_out); else n_pass++;

    issue(OP_ROR, 1'b1, 16'h0001, 16'h0001, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (out !== 16'h0080) $display("FAIL ror8_out: got %h want 0080", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0801) $display("FAIL ror8_flags: got %h want 0801", flags_out); else n_pass++;

    issue(OP_ROL, 1'b0, 16'h8001, 16'h0020, 16'h00C5);
    wait_done(1, lat);
    n_checks++; if (lat !== 1) $display("FAIL rol0_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (out !== 16'h8001) $display("FAIL rol0_out: got %h want 8001", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h00C5) $display("FAIL rol0_flags: got %h want 00c5", flags_out); else n_pass++;

    issue(OP_ROL, 1'b0, 16'h1234, 16'h0004, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (lat !== 4) $display("FAIL rol4_lat: got %0d want 4", lat); else n_pass++;
    n_checks++; if (out !== 16'h2341) $display("FAIL rol4_out: got %h want 2341", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0001) $display("FAIL rol4_flags: got %h want 0001", flags_out); else n_pass++;
  endtask

  task automatic test_mul();
`ifdef SEQ_ALU_MUL_EN
    issue(OP_MUL, 1'b0, 16'hFFFF, 16'h0002, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (lat !== 16) $display("FAIL mul16_lat: got %0d want 16", lat); else n_pass++;
    n_checks++; if (out !== 16'hFFFE) $display("FAIL mul16_out: got %h want fffe", out); else n_pass++;
    n_checks++; if (out_hi !== 16'h0001) $display("FAIL mul16_hi: got %h want 0001", out_hi); else n_pass++;
    n_checks++; if (flags_out !== 16'h0881) $display("FAIL mul16_flags: got %h want 0881", flags_out); else n_pass++;

    issue(OP_MUL, 1'b1, 16'h000C, 16'h000B, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (lat !== 8) $display("FAIL mul8_lat: got %0d want 8", lat); else n_pass++;
    n_checks++; if (out !== 16'h0084) $display("FAIL mul8_out: got %h want 0084", out); else n_pass++;
    n_checks++; if (out_hi !== 16'h0000) $display("FAIL mul8_hi: got %h want 0000", out_hi); else n_pass++;
    n_checks++; if (flags_out !== 16'h0084) $display("FAIL mul8_flags: got %h want 0084", flags_out); else n_pass++;
`else
    issue(OP_MUL, 1'b0, 16'hFFFF, 16'h0002, 16'h0001);
    wait_done(1, lat);
    n_checks++; if (lat !== 1) $display("FAIL mul_off_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (out !== 16'hFFFF) $display("FAIL mul_off_out: got %h want ffff", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0001) $display("FAIL mul_off_flags: got %h want 0001", flags_out); else n_pass++;
`endif
    issue(alu_op_t'(4'd15), 1'b0, 16'hABCD, 16'h1111, 16'h0046);
    wait_done(1, lat);
    n_checks++; if (lat !== 1) $display("FAIL unsup_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (out !== 16'hABCD) $display("FAIL unsup_out: got %h want abcd", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0046) $display("FAIL unsup_flags: got %h want 0046", flags_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(OP_SHL, 1'b0, 16'h0001, 16'h0002, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (out !== 16'h0004) $display("FAIL b2b_shl_out: got %h want 0004", out); else n_pass++;
    issue(OP_ADD, 1'b0, 16'h0001, 16'h0001, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (lat !== 1) $display("FAIL b2b_add_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (out !== 16'h0002) $display("FAIL b2b_add_out: got %h want 0002", out); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL b2b_pulse: got %b want 0", done); else n_pass++;
    n_checks++; if (out !== 16'h0002) $display("FAIL b2b_hold: got %h want 0002", out); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    issue(OP_SHR, 1'b0, 16'h0100, 16'h0005, 16'h0800);
    start = 1'b1; op = OP_ADD; is_8_bit = 1'b0; a = 16'h7FFF; b = 16'h0001; flags_in = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat);
    n_checks++; if (lat !== 5) $display("FAIL busy_ign_lat: got %0d want 5", lat); else n_pass++;
    n_checks++; if (out !== 16'h0008) $display("FAIL busy_ign_out: got %h want 0008", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0800) $display("FAIL busy_ign_flags: got %h want 0800", flags_out); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL busy_ign_extra_done: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic seen;
    seen = 1'b0;
    issue(OP_ROL, 1'b0, 16'h0001, 16'h000A, 16'h0000);
    seen = seen | done;
    start = 1'b1; op = OP_ADD; is_8_bit = 1'b0; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    seen = seen | done;
    start = 1'b0;
    @(negedge clk);
    seen = seen | done;
    @(negedge clk);
    seen = seen | done;
    reset = 1'b1; start = 1'b1; op = OP_ADD; a = 16'h0003; b = 16'h0004;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (out !== 16'h0) $display("FAIL abort_out: got %h want 0000", out); else n_pass++;
    n_checks++; if (out_hi !== 16'h0) $display("FAIL abort_out_hi: got %h want 0000", out_hi); else n_pass++;
    n_checks++; if (flags_out !== 16'h0) $display("FAIL abort_flags: got %h want 0000", flags_out); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      seen = seen | done;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_done: got %b want 0", seen); else n_pass++;
    issue(OP_ADD, 1'b0, 16'h0002, 16'h0003, 16'h0000);
    wait_done(1, lat);
    n_checks++; if (lat !== 1) $display("FAIL post_abort_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (out !== 16'h0005) $display("FAIL post_abort_out: got %h want 0005", out); else n_pass++;
    n_checks++; if (flags_out !== 16'h0004) $display("FAIL post_abort_flags: got %h want 0004", flags_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
